// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
// Opcodes, field formats and sequencing states.
package instr_encoder_pkg;

    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [2:0] FUNCT3_W = 3'b010;

    typedef enum logic [1:0] {
        FMT_I_ALU = 2'd0,
        FMT_LW    = 2'd1,
        FMT_S     = 2'd2,
        FMT_SB    = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A 13-bit immediate fits the 12-bit signed field when its top two bits agree.
    function automatic logic fits_12(input logic [12:0] imm);
        return (imm[12] == imm[11]);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: decoded fields plus format in, 32-bit RV32I word
// and an immediate-range legality flag out.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic [31:0] instr_o,
    output logic        legal_o
);

    // Field placement per format; SB immediates are byte offsets and must be even.
    always_comb begin
        instr_o = 32'h0000_0000;
        legal_o = 1'b0;
        case (fmt_i)
            FMT_I_ALU: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I_ALU};
                legal_o = fits_12(imm_i);
            end
            FMT_LW: begin
                instr_o = {imm_i[11:0], rs1_i, FUNCT3_W, rd_i, OP_LW};
                legal_o = fits_12(imm_i);
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, FUNCT3_W, imm_i[4:0], OP_S};
                legal_o = fits_12(imm_i);
            end
            FMT_SB: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_SB};
                legal_o = (imm_i[0] == 1'b0);
            end
            default: begin
                instr_o = 32'h0000_0000;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: valid/ready stream of decoded fields in, addressed
// RV32I words out, with sticky error/overflow flags and RUN/DONE sequencing.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        fmt_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [12:0]       imm_i,
    input  logic              last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              err_o,
    output logic              ovf_o,
    output logic              done_o
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              out_valid_r;
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] count_r;
    logic              err_r;
    logic              ovf_r;
    logic              last_pending_r;
    logic              out_last_r;

    logic [31:0]       packed_s;
    logic              legal_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              out_hs_s;
    logic [ADDR_W-1:0] addr_inc_s;
    logic [ADDR_W-1:0] beat_addr_s;

    instr_pack u_pack (
        .fmt_i    (fmt_i),
        .funct3_i (funct3_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .imm_i    (imm_i),
        .instr_o  (packed_s),
        .legal_o  (legal_s)
    );

    // start_i wins over both handshakes, so gate them here once.
    assign in_ready_s  = (state_r == ST_RUN) && (!out_valid_r || out_ready_i)
                         && !last_pending_r && !start_i;
    assign accept_s    = in_valid_i && in_ready_s;
    assign out_hs_s    = out_valid_r && out_ready_i && !start_i;
    assign addr_inc_s  = next_addr_r + ADDR_W'(1);
    // A beat accepted alongside the drain of the previous word takes the following address.
    assign beat_addr_s = out_hs_s ? addr_inc_s : next_addr_r;

    // Sequencing state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an illegal last beat ends the program without emitting.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_nxt_s = ST_RUN;
                else         state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (start_i)                                  state_nxt_s = ST_RUN;
                else if (out_hs_s && out_last_r)              state_nxt_s = ST_DONE;
                else if (accept_s && !legal_s && last_i)      state_nxt_s = ST_DONE;
                else                                          state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (start_i) state_nxt_s = ST_RUN;
                else         state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output word register, address/count tracking and sticky flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_r    <= 1'b0;
            instr_r        <= 32'h0000_0000;
            addr_r         <= BASE_ADDR;
            next_addr_r    <= BASE_ADDR;
            count_r        <= '0;
            err_r          <= 1'b0;
            ovf_r          <= 1'b0;
            last_pending_r <= 1'b0;
            out_last_r     <= 1'b0;
        end else if (start_i) begin
            out_valid_r    <= 1'b0;
            addr_r         <= BASE_ADDR;
            next_addr_r    <= BASE_ADDR;
            count_r        <= '0;
            err_r          <= 1'b0;
            ovf_r          <= 1'b0;
            last_pending_r <= 1'b0;
            out_last_r     <= 1'b0;
        end else begin
            if (out_hs_s) begin
                out_valid_r    <= 1'b0;
                last_pending_r <= 1'b0;
                next_addr_r    <= addr_inc_s;
                count_r        <= count_r + ADDR_W'(1);
                if (next_addr_r == {ADDR_W{1'b1}}) ovf_r <= 1'b1;
            end
            if (accept_s && legal_s) begin
                out_valid_r    <= 1'b1;
                instr_r        <= packed_s;
                addr_r         <= beat_addr_s;
                out_last_r     <= last_i;
                last_pending_r <= last_i;
            end
            if (accept_s && !legal_s) err_r <= 1'b1;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign instr_o     = instr_r;
    assign addr_o      = addr_r;
    assign count_o     = count_r;
    assign err_o       = err_r;
    assign ovf_o       = ovf_r;
    assign done_o      = (state_r == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; a second instance with
// ADDR_W=2 shares the stimulus to exercise address wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  fmt = 2'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [12:0] imm = 13'd0;
    logic        last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, err, ovf, done;
    logic [31:0] instr;
    logic [7:0]  addr, count;
    logic        in_ready2, out_valid2, err2, ovf2, done2;
    logic [31:0] instr2;
    logic [1:0]  addr2, count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .fmt_i(fmt), .funct3_i(funct3), .rd_i(rd),
        .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .last_i(last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .instr_o(instr),
        .addr_o(addr), .count_o(count), .err_o(err), .ovf_o(ovf), .done_o(done)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .fmt_i(fmt), .funct3_i(funct3), .rd_i(rd),
        .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .last_i(last),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .instr_o(instr2),
        .addr_o(addr2), .count_o(count2), .err_o(err2), .ovf_o(ovf2), .done_o(done2)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_beat(input logic [1:0] f, input logic [2:0] f3, input logic [4:0] rd_v,
                            input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                            input logic [12:0] imm_v, input logic last_v);
        in_valid = 1'b1; fmt = f; funct3 = f3; rd = rd_v;
        rs1 = rs1_v; rs2 = rs2_v; imm = imm_v; last = last_v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
        checks++; if (addr !== 8'h00 || count !== 8'h00) begin errors++; $display("FAIL reset_addr_count: got %h/%h exp 00/00", addr, count); end
        checks++; if ({err, ovf, done, in_ready} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {err, ovf, done, in_ready}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_ialu();
        pulse_start();
        out_ready = 1'b0;
        set_beat(2'd0, 3'b000, 5'd5, 5'd1, 5'd0, 13'h1FFF, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ialu_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || instr !== 32'hFFF08293) begin errors++; $display("FAIL ialu_instr: got %b/%h exp 1/fff08293", out_valid, instr); end
        checks++; if (addr !== 8'd0 || count !== 8'd0) begin errors++; $display("FAIL ialu_addr: got %0d/%0d exp 0/0", addr, count); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 8'd1) begin errors++; $display("FAIL ialu_hs: got %b/%0d exp 0/1", out_valid, count); end
    endtask

    task automatic test_s_sb_last();
        pulse_start();
        out_ready = 1'b1;
        set_beat(2'd2, 3'b000, 5'd0, 5'd3, 5'd2, 13'd8, 1'b0);
        tick();
        set_beat(2'd3, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
        #1;
        checks++; if (instr !== 32'h0021A423 || addr !== 8'd0) begin errors++; $display("FAIL s_word: got %h@%0d exp 0021a423@0", instr, addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL s_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0; last = 1'b0;
        checks++; if (instr !== 32'hFE208EE3 || addr !== 8'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL sb_word: got %h@%0d v%b exp fe208ee3@1 v1", instr, addr, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL last_pending_ready: got %b exp 0", in_ready); end
        tick();
        checks++; if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL done_state: got d%b r%b v%b exp d1 r0 v0", done, in_ready, out_valid); end
        checks++; if (count !== 8'd2 || addr !== 8'd1) begin errors++; $display("FAIL done_hold: got %0d/%0d exp 2/1", count, addr); end
    endtask

    task automatic test_backpressure();
        pulse_start();
        out_ready = 1'b0;
        set_beat(2'd0, 3'b000, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0);
        tick();
        set_beat(2'd0, 3'b000, 5'd2, 5'd0, 5'd0, 13'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (instr !== 32'h00100093 || addr !== 8'd0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d: got %h@%0d v%b r%b exp 00100093@0 v1 r0", i, instr, addr, out_valid, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (instr !== 32'h00200113 || addr !== 8'd1 || count !== 8'd1) begin errors++; $display("FAIL bp_second: got %h@%0d c%0d exp 00200113@1 c1", instr, addr, count); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 8'd2) begin errors++; $display("FAIL bp_drain: got v%b c%0d exp v0 c2", out_valid, count); end
    endtask

    task automatic test_illegal();
        pulse_start();
        out_ready = 1'b1;
        set_beat(2'd0, 3'b000, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0);
        tick();
        checks++; if (err !== 1'b1 || out_valid !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL ill_ialu: got e%b v%b c%0d exp e1 v0 c0", err, out_valid, count); end
        set_beat(2'd3, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
        tick();
        checks++; if (err !== 1'b1 || out_valid !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL ill_sb: got e%b v%b c%0d exp e1 v0 c0", err, out_valid, count); end
        set_beat(2'd0, 3'b000, 5'd3, 5'd0, 5'd0, 13'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (instr !== 32'h00300193 || addr !== 8'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_next_addr: got %h@%0d v%b exp 00300193@0 v1", instr, addr, out_valid); end
        tick();
        set_beat(2'd0, 3'b000, 5'd4, 5'd0, 5'd0, 13'h17FF, 1'b1);
        tick();
        in_valid = 1'b0; last = 1'b0;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0 || count !== 8'd1 || err !== 1'b1) begin errors++; $display("FAIL ill_last: got d%b v%b c%0d e%b exp d1 v0 c1 e1", done, out_valid, count, err); end
    endtask

    task automatic test_wrap();
        logic [1:0]  exp_a;
        logic [31:0] exp_i;
        pulse_start();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(2'd0, 3'b000, 5'(i + 1), 5'd0, 5'd0, 13'(i), 1'b0);
            tick();
            exp_a = 2'(i % 4);
            exp_i = {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
            checks++; if (addr2 !== exp_a || instr2 !== exp_i || ovf2 !== (i == 4)) begin errors++; $display("FAIL wrap%0d: got %h@%0d ovf%b exp %h@%0d ovf%b", i, instr2, addr2, ovf2, exp_i, exp_a, (i == 4)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (count2 !== 2'd1 || ovf2 !== 1'b1 || count !== 8'd5) begin errors++; $display("FAIL wrap_count: got %0d ovf%b wide%0d exp 1 ovf1 wide5", count2, ovf2, count); end
    endtask

    task automatic test_start_midstream();
        out_ready = 1'b0;
        set_beat(2'd1, 3'b000, 5'd6, 5'd2, 5'd0, 13'd4, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || instr !== 32'h00412303 || addr !== 8'd5) begin errors++; $display("FAIL mid_lw: got v%b %h@%0d exp v1 00412303@5", out_valid, instr, addr); end
        start = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL start_ready: got %b exp 0", in_ready); end
        tick();
        start = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || addr !== 8'd0 || count !== 8'd0) begin errors++; $display("FAIL start_clear: got v%b a%0d c%0d exp v0 a0 c0", out_valid, addr, count); end
        checks++; if (ovf2 !== 1'b0 || addr2 !== 2'd0 || out_valid2 !== 1'b0) begin errors++; $display("FAIL start_clear2: got ovf%b a%0d v%b exp ovf0 a0 v0", ovf2, addr2, out_valid2); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_beat(2'd0, 3'b000, 5'd7, 5'd0, 5'd0, 13'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || instr !== 32'h0 || addr !== 8'd0 || count !== 8'd0) begin errors++; $display("FAIL rst_mid_out: got v%b %h a%0d c%0d exp v0 0 a0 c0", out_valid, instr, addr, count); end
        checks++; if ({err, ovf, done, in_ready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b exp 0000", {err, ovf, done, in_ready}); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_ialu();
        test_s_sb_last();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_start_midstream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder: the write-side counterpart of the core's immediate generator. It accepts decoded fields (format, registers, funct3, signed immediate) over a valid/ready stream. It packs each into a 32-bit RV32I word (I-ALU, LW, SW, BEQ-class SB formats) and emits it with a sequential word address for loading instruction memory in testbench or boot flows. It has a 1-deep registered output, sticky error/overflow flags and a RUN/DONE sequencing state machine.

Parameters:
ADDR_W, 8, word-address width of addr_o and count_o
BASE_ADDR, 0, word address of the first emitted instruction after start

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  pulse: flush, reload address, clear flags/count, enter RUN
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when valid&ready
fmt_i  in  2  0=I-ALU(0010011) 1=LW(0000011) 2=S(0100011) 3=SB(1100011)
funct3_i  in  3  used for I-ALU and SB; ignored for LW/S (forced 010)
rd_i  in  5  destination reg; ignored for S/SB
rs1_i  in  5  source reg 1
rs2_i  in  5  source reg 2; ignored for I-ALU/LW
imm_i  in  13  signed immediate; SB = byte offset
last_i  in  1  marks final beat of program
out_valid_o  out  1  instr_o/addr_o valid
out_ready_i  in  1  sink accepts when out_valid_o&out_ready_i
instr_o  out  32  encoded instruction
addr_o  out  ADDR_W  word address of instr_o
count_o  out  ADDR_W  instructions emitted since start
err_o  out  1  sticky: at least one beat dropped for bad immediate
ovf_o  out  1  sticky: address wrapped past 2^ADDR_W-1
done_o  out  1  high in DONE state

Behaviour:
- Reset (async, rst_n_i=0): state IDLE. out_valid_o=0, instr_o=0, addr_o=BASE_ADDR, count_o=0, err_o=0, ovf_o=0, done_o=0, in_ready_o=0.
- States: IDLE -(start_i)-> RUN; RUN -(last beat emitted, i.e. output handshake on the beat tagged last)-> DONE; DONE -(start_i)-> RUN. start_i in any state, including mid-stream RUN, has these effects: clear out_valid_o (pending word discarded), addr_o=BASE_ADDR, count_o=0, err_o=ovf_o=0. start_i has priority over any same-cycle handshake. No beat is accepted in the start cycle.
- in_ready_o = (state==RUN) & (!out_valid_o | out_ready_i) & !last_pending. Full throughput, 1 word per cycle.
- Latency: an accepted beat appears on instr_o exactly 1 cycle later. instr_o/addr_o/out_valid_o hold stable while out_valid_o&!out_ready_i.
- Encoding (imm = imm_i):
  - I-ALU: {imm[11:0],rs1,funct3,rd,0010011}.
  - LW: {imm[11:0],rs1,010,rd,0000011}.
  - S: {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
  - SB: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],1100011}.
- Range check at acceptance:
  - fmt 0–2 legal iff imm[12]==imm[11] (fits 12-bit signed).
  - SB legal iff imm[0]==0.
  - Illegal beat: consumed (handshake completes) but not emitted, not counted, address unchanged; err_o set next cycle.
  - Illegal beat with last_i: state still goes to DONE in the cycle after acceptance, with no output word.
- Address: addr_o of each emitted word = BASE_ADDR + count at acceptance, mod 2^ADDR_W. On the output handshake, the internal next-address increments. A wrap from all-ones to 0 sets ovf_o; emission continues.
- count_o increments on each output handshake and wraps with the address.
- last_pending: set when a legal last beat is accepted, cleared on its output handshake; blocks further input.
- DONE: in_ready_o=0, out_valid_o=0, done_o=1; addr_o/count_o/err_o/ovf_o hold.

Decomposition:
- Shared package: opcode constants (OP_I_ALU, OP_LW, OP_S, OP_SB), fmt enum, state enum {IDLE,RUN,DONE}, FUNCT3_W (010).
- One natural combinational sub-module: instr_pack (fields+fmt -> 32-bit word + legal flag).
- Top level holds the FSM, output register, address/count and flags.

Test Plan:
- Reset, start, I-ALU rd=5 rs1=1 f3=000 imm=-1 -> next cycle instr_o=0xFFF08293, addr_o=0, count_o=1 after handshake.
- S rs1=3 rs2=2 imm=8, then SB f3=000 rs1=1 rs2=2 imm=-4 last=1, out_ready_i=1 -> 0x0021A423 @0, 0xFE208EE3 @1, then done_o=1, in_ready_o=0.
- Back-pressure: out_ready_i=0 for 3 cycles with a word pending -> instr_o/addr_o stable, in_ready_o=0; release -> words in order with no loss or duplication.
- I-ALU imm=2048, then SB imm=3 -> both dropped, err_o=1, count_o unchanged; a following legal beat gets the unchanged address.
- ADDR_W=2: emit 5 legal words -> addresses 0,1,2,3,0; ovf_o=1 after the 4th handshake.
- start_i mid-stream with a word pending and out_ready_i=0 -> out_valid_o=0 next cycle, addr_o=0, flags cleared. Reset asserted mid-stream -> all outputs at reset values immediately.
